// File: rtl/parking_gate_controller.sv
// Shared lot gate sequencer: arbitrates entry/exit lane requests, runs the gate
// open/timeout/cooldown cycle, and keeps the registered occupancy counts.
module parking_gate_controller #(
  parameter int CAPACITY     = 7,
  parameter int OPEN_TIMEOUT = 8,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic       car_passed,
  output logic       entry_grant,
  output logic       exit_grant,
  output logic       gate_open,
  output logic [2:0] parked,
  output logic [2:0] empty,
  output logic       full,
  output logic       lot_empty,
  output logic       timeout
);

  localparam int OT_W = $clog2(OPEN_TIMEOUT);
  localparam int HD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [2:0]      CAP     = 3'(CAPACITY);
  localparam logic [OT_W-1:0] OT_LAST = OT_W'(OPEN_TIMEOUT - 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE_ENTRY,
    S_SERVE_EXIT,
    S_HOLD
  } state_t;

  typedef enum logic {
    LANE_ENTRY,
    LANE_EXIT
  } lane_t;

  state_t          state;
  lane_t           prio;
  logic [OT_W-1:0] open_timer;
  logic [HD_W-1:0] hold_timer;

  logic       entry_ok;
  logic       exit_ok;
  logic       pick_entry;
  logic [2:0] parked_up;
  logic [2:0] parked_dn;
  logic [2:0] parked_pass;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    entry_ok    = entry_req && !full;
    exit_ok     = exit_req && !lot_empty;
    pick_entry  = entry_ok && (!exit_ok || prio == LANE_ENTRY);
    // Defensive saturation even though eligibility already prevents overflow.
    parked_up   = (parked >= CAP) ? CAP : parked + 3'd1;
    parked_dn   = (parked == 3'd0) ? 3'd0 : parked - 3'd1;
    parked_pass = (state == S_SERVE_ENTRY) ? parked_up : parked_dn;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  // NOTE: the asynchronous reset clears every register, including mid-service,
  // so the gate drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      prio        <= LANE_ENTRY;
      open_timer  <= '0;
      hold_timer  <= '0;
      parked      <= 3'd0;
      empty       <= CAP;
      full        <= 1'b0;
      lot_empty   <= 1'b1;
      gate_open   <= 1'b0;
      entry_grant <= 1'b0;
      exit_grant  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      entry_grant <= 1'b0;
      exit_grant  <= 1'b0;
      timeout     <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (entry_ok || exit_ok) begin
            gate_open  <= 1'b1;
            open_timer <= '0;
            if (pick_entry) begin
              state       <= S_SERVE_ENTRY;
              entry_grant <= 1'b1;
              prio        <= LANE_EXIT;
            end else begin
              state       <= S_SERVE_EXIT;
              exit_grant  <= 1'b1;
              prio        <= LANE_ENTRY;
            end
          end
        end

        S_SERVE_ENTRY, S_SERVE_EXIT: begin
          // A pass on the final timer cycle wins over the timeout.
          if (car_passed) begin
            parked     <= parked_pass;
            empty      <= CAP - parked_pass;
            full       <= (parked_pass == CAP);
            lot_empty  <= (parked_pass == 3'd0);
            gate_open  <= 1'b0;
            hold_timer <= '0;
            state      <= S_HOLD;
          end else if (open_timer == OT_LAST) begin
            timeout    <= 1'b1;
            gate_open  <= 1'b0;
            hold_timer <= '0;
            state      <= S_HOLD;
          end else begin
            open_timer <= open_timer + OT_W'(1);
          end
        end

        S_HOLD: begin
          if (hold_timer == HD_LAST) begin
            state <= S_IDLE;
          end else begin
            hold_timer <= hold_timer + HD_W'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

endmodule
